// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the latency-counter width.
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Encoding 3 is illegal and is flagged as an error elsewhere; its byte
   // count only has to keep the range check well defined.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_bytes = 3'd1;
         SIZE_HALF: size_bytes = 3'd2;
         default:   size_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the responder: extends load data from the bytes at
// idx..idx+3 and produces per-byte write enables for stores.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [31:0] rbytes,
   input  logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic [3:0]  wen,
   output logic [31:0] wbytes
);

   // Byte k of rbytes/wbytes always maps to array index idx+k, so stores need
   // no shifting: only the low 'size' bytes are enabled.
   always_comb begin
      ldata  = rbytes;
      wen    = 4'b1111;
      wbytes = wdata;
      case (size)
         SIZE_BYTE: begin
            ldata = {{24{rbytes[7] & ~is_unsigned}}, rbytes[7:0]};
            wen   = 4'b0001;
         end
         SIZE_HALF: begin
            ldata = {{16{rbytes[15] & ~is_unsigned}}, rbytes[15:0]};
            wen   = 4'b0011;
         end
         SIZE_WORD: begin
            ldata = rbytes;
            wen   = 4'b1111;
         end
         default: begin
            ldata = '0;
            wen   = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory target with a fixed response latency, a
// little-endian byte array and error reporting for bad accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int               DATAW     = 32,
   parameter logic [DATAW-1:0] BASE_ADDR = 32'h01000000,
   parameter int               MEM_DEPTH = 1048576,
   parameter int               LATENCY   = 2,
   parameter string            MEM_FILE  = ""
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [DATAW-1:0] req_addr,
   input  logic [DATAW-1:0] req_wdata,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [DATAW-1:0] resp_rdata,
   output logic             resp_err
);

   localparam int AW = $clog2(MEM_DEPTH);

   logic [7:0] mem [MEM_DEPTH];

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [DATAW-1:0]   addr_q, addr_d;
   logic [DATAW-1:0]   wdata_q, wdata_d;
   logic [1:0]         size_q, size_d;
   logic               uns_q, uns_d;
   logic [DATAW-1:0]   rdata_q, rdata_d;
   logic               err_q, err_d;

   logic               cur_write, cur_uns, commit, err_c;
   logic [DATAW-1:0]   cur_addr, cur_wdata, idx;
   logic [1:0]         cur_size;
   logic [DATAW:0]     end_w;
   logic [AW-1:0]      base_i;
   logic [31:0]        rbytes, ldata, wbytes;
   logic [3:0]         wen;

   // With LATENCY=1 the commit happens on the accepting edge, so the access
   // is evaluated from the live request while IDLE and from the capture after.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_write = req_write;
         cur_addr  = req_addr;
         cur_wdata = req_wdata;
         cur_size  = req_size;
         cur_uns   = req_unsigned;
      end else begin
         cur_write = write_q;
         cur_addr  = addr_q;
         cur_wdata = wdata_q;
         cur_size  = size_q;
         cur_uns   = uns_q;
      end
      idx    = cur_addr - BASE_ADDR;
      end_w  = {1'b0, idx} + {{(DATAW-2){1'b0}}, size_bytes(cur_size)};
      err_c  = (end_w > (DATAW+1)'(MEM_DEPTH))
             || (cur_size == SIZE_HALF && cur_addr[0])
             || (cur_size == SIZE_WORD && cur_addr[1:0] != 2'b00)
             || (cur_size == 2'd3);
      base_i = idx[AW-1:0];
      for (int k = 0; k < 4; k++) begin
         rbytes[8*k +: 8] = mem[base_i + AW'(k)];
      end
   end

   dmem_lane_align u_lane (
      .size        (cur_size),
      .is_unsigned (cur_uns),
      .rbytes      (rbytes),
      .wdata       (cur_wdata),
      .ldata       (ldata),
      .wen         (wen),
      .wbytes      (wbytes)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               size_d  = req_size;
               uns_d   = req_unsigned;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (commit) begin
         err_d   = err_c;
         rdata_d = (err_c || cur_write) ? '0 : DATAW'(ldata);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
   end

   // A store interrupted by reset on its commit edge must leave the array alone.
   always_ff @(posedge clock) begin
      if (!reset && commit && cur_write && !err_c) begin
         for (int k = 0; k < 4; k++) begin
            if (wen[k]) mem[base_i + AW'(k)] <= wbytes[8*k +: 8];
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY=2 with hand-computed results.
module tb_dmem_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   dmem_responder dut (
      .clock        (clock),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction with resp_ready held high; lat counts edges from
   // acceptance until resp_valid is visible.
   task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u,
                       output logic [31:0] rd, output logic er, output int lat);
      @(negedge clock);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
      req_size = sz; req_unsigned = u; resp_ready = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      @(posedge clock); #1;
   endtask

   logic [31:0] rd, hold_rd;
   logic        er;
   int          lat;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'h0);
      check("rst_err", 32'(resp_err), 32'd0);

      xact(1, 32'h01000010, 32'hDEADBEEF, 2'd2, 0, rd, er, lat);
      check("st_word_lat", 32'(lat), 32'd2);
      check("st_word_err", 32'(er), 32'd0);
      check("st_word_rdata", rd, 32'h0);
      xact(0, 32'h01000010, 32'h0, 2'd2, 0, rd, er, lat);
      check("ld_word_lat", 32'(lat), 32'd2);
      check("ld_word", rd, 32'hDEADBEEF);
      check("ld_word_err", 32'(er), 32'd0);

      xact(0, 32'h01000013, 32'h0, 2'd0, 0, rd, er, lat);
      check("ld_byte_s", rd, 32'hFFFFFFDE);
      xact(0, 32'h01000013, 32'h0, 2'd0, 1, rd, er, lat);
      check("ld_byte_u", rd, 32'h000000DE);
      xact(0, 32'h01000010, 32'h0, 2'd1, 0, rd, er, lat);
      check("ld_half_s", rd, 32'hFFFFBEEF);
      xact(0, 32'h01000012, 32'h0, 2'd1, 1, rd, er, lat);
      check("ld_half_u", rd, 32'h0000DEAD);
      xact(0, 32'h01000010, 32'h0, 2'd0, 0, rd, er, lat);
      check("ld_byte_s_pos", rd, 32'hFFFFFFEF);

      xact(1, 32'h01000011, 32'h00000055, 2'd0, 0, rd, er, lat);
      check("st_byte_err", 32'(er), 32'd0);
      xact(0, 32'h01000010, 32'h0, 2'd2, 0, rd, er, lat);
      check("partial_store", rd, 32'hDEAD55EF);

      xact(0, 32'h01000001, 32'h0, 2'd1, 0, rd, er, lat);
      check("mis_half_err", 32'(er), 32'd1);
      check("mis_half_rdata", rd, 32'h0);

      xact(1, 32'h01000000, 32'h11223344, 2'd2, 0, rd, er, lat);
      xact(1, 32'h01000004, 32'h55667788, 2'd2, 0, rd, er, lat);
      xact(1, 32'h01000002, 32'hCAFEF00D, 2'd2, 0, rd, er, lat);
      check("mis_store_err", 32'(er), 32'd1);
      xact(0, 32'h01000000, 32'h0, 2'd2, 0, rd, er, lat);
      check("mis_store_keep0", rd, 32'h11223344);
      xact(0, 32'h01000004, 32'h0, 2'd2, 0, rd, er, lat);
      check("mis_store_keep4", rd, 32'h55667788);

      xact(0, 32'h00FFFFFC, 32'h0, 2'd2, 0, rd, er, lat);
      check("below_base_err", 32'(er), 32'd1);
      check("below_base_rdata", rd, 32'h0);
      xact(0, 32'h010FFFFE, 32'h0, 2'd2, 0, rd, er, lat);
      check("past_end_err", 32'(er), 32'd1);
      xact(0, 32'h01100000, 32'h0, 2'd0, 0, rd, er, lat);
      check("byte_at_end_err", 32'(er), 32'd1);
      xact(1, 32'h010FFFFC, 32'h0BADF00D, 2'd2, 0, rd, er, lat);
      check("last_word_err", 32'(er), 32'd0);
      xact(0, 32'h010FFFFC, 32'h0, 2'd2, 0, rd, er, lat);
      check("last_word", rd, 32'h0BADF00D);
      xact(0, 32'h01000010, 32'h0, 2'd3, 0, rd, er, lat);
      check("size3_err", 32'(er), 32'd1);
      check("size3_rdata", rd, 32'h0);

      // Back-pressure: response must hold while resp_ready is low.
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h01000010;
      req_size = 2'd2; req_unsigned = 1'b0; resp_ready = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      check("bp_lat", 32'(lat), 32'd2);
      hold_rd = resp_rdata;
      check("bp_rdata", hold_rd, 32'hDEAD55EF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("bp_valid_hold", 32'(resp_valid), 32'd1);
         check("bp_rdata_hold", resp_rdata, hold_rd);
         check("bp_err_hold", 32'(resp_err), 32'd0);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clock); #1;
      check("bp_release_ready", 32'(req_ready), 32'd1);
      check("bp_release_valid", 32'(resp_valid), 32'd0);

      // Reset while a store waits: the store must not reach the array.
      xact(1, 32'h01000020, 32'hAAAAAAAA, 2'd2, 0, rd, er, lat);
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h01000020;
      req_wdata = 32'h12345678; req_size = 2'd2;
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("wait_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("rst_wait_ready", 32'(req_ready), 32'd1);
      check("rst_wait_valid", 32'(resp_valid), 32'd0);
      repeat (3) @(posedge clock);
      #1 check("rst_wait_idle", 32'(resp_valid), 32'd0);
      xact(0, 32'h01000020, 32'h0, 2'd2, 0, rd, er, lat);
      check("rst_no_commit", rd, 32'hAAAAAAAA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
